// File: rtl/f2s_handshake_rx.sv
// rtl/f2s_handshake_rx.sv - bclk-side receiver of a four-phase req/ack crossing with bundled data
// Optional request-hold timeout flag enabled by defining TIMEOUT_EN.
module f2s_handshake_rx #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
`ifdef TIMEOUT_EN
  ,parameter int TO_CYCLES  = 64
`endif
) (
  input  logic          bclk,
  input  logic          rst,
  input  logic          areq,
  input  logic [DW-1:0] adat,
  output logic          aack,
  output logic [DW-1:0] bdat,
  output logic          bvalid,
`ifdef TIMEOUT_EN
  output logic          to_err,
`endif
  input  logic          bready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   areq_s;
  logic                   primed;
  logic                   aack_n;
  logic                   bvalid_n;
  logic                   capture;

  // prime_q marks when the last sync stage holds a post-reset sample, so a
  // request held high through reset cannot masquerade as a low in DRAIN.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], areq};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign areq_s = sync_q[SYNC_STAGES-1];
  assign primed = prime_q[SYNC_STAGES-1];

  always_comb begin
    state_n  = state;
    aack_n   = aack;
    bvalid_n = bvalid;
    capture  = 1'b0;
    case (state)
      DRAIN: begin
        aack_n   = 1'b0;
        bvalid_n = 1'b0;
        if (primed && !areq_s) state_n = IDLE;
      end
      IDLE: begin
        aack_n   = 1'b0;
        bvalid_n = 1'b0;
        if (areq_s) begin
          capture  = 1'b1;
          bvalid_n = 1'b1;
          state_n  = VALID;
        end
      end
      VALID: begin
        if (bready) begin
          bvalid_n = 1'b0;
          aack_n   = 1'b1;
          state_n  = ACK;
        end
      end
      ACK: begin
        if (!areq_s) begin
          aack_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = DRAIN;
    endcase
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state  <= DRAIN;
      aack   <= 1'b0;
      bvalid <= 1'b0;
      bdat   <= '0;
    end else begin
      state  <= state_n;
      aack   <= aack_n;
      bvalid <= bvalid_n;
      if (capture) bdat <= adat;
    end
  end

`ifdef TIMEOUT_EN
  localparam int CW = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;

  logic [CW-1:0] to_cnt;
  logic [CW-1:0] to_cnt_inc;

  assign to_cnt_inc = (to_cnt >= CW'(TO_CYCLES)) ? to_cnt : to_cnt + 1'b1;

  // to_cnt is the number of edges already spent in ACK; the flag only observes the FSM.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (state == VALID && state_n == ACK) to_cnt <= '0;
      else if (state == ACK)                to_cnt <= to_cnt_inc;
      if (state == ACK && areq_s && to_cnt_inc >= CW'(TO_CYCLES)) to_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_f2s_handshake_rx.sv
// tb/tb_f2s_handshake_rx.sv - randomized self-checking bench for f2s_handshake_rx
`timescale 1ns/1ps
module tb_f2s_handshake_rx;
  localparam int DW  = 8;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic          bclk = 1'b0;
  logic          aclk = 1'b0;
  logic          rst;
  logic          areq;
  logic [DW-1:0] adat;
  logic          bready;
  logic          aack;
  logic [DW-1:0] bdat;
  logic          bvalid;
`ifdef TIMEOUT_EN
  logic          to_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic          ack_s1 = 1'b0;
  logic          ack_s2 = 1'b0;
  logic          done;
  int            beats;

  always #10 bclk = ~bclk;
  always #7  aclk = ~aclk;

  always @(posedge aclk) begin
    ack_s1 <= aack;
    ack_s2 <= ack_s1;
  end

  f2s_handshake_rx #(
    .DW(DW),
    .SYNC_STAGES(SS)
`ifdef TIMEOUT_EN
    ,.TO_CYCLES(16)
`endif
  ) dut (
    .bclk(bclk),
    .rst(rst),
    .areq(areq),
    .adat(adat),
    .aack(aack),
    .bdat(bdat),
    .bvalid(bvalid),
`ifdef TIMEOUT_EN
    .to_err(to_err),
`endif
    .bready(bready)
  );

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge bclk);
    #3 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (2 * LAT + 2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; areq = 1'b0; adat = '0; bready = 1'b0;
    #3;
    checks++; if (aack !== 1'b0) begin failures++; $display("FAIL reset_aack: got %b want 0", aack); end
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL reset_bvalid: got %b want 0", bvalid); end
    checks++; if (bdat !== '0) begin failures++; $display("FAIL reset_bdat: got %h want 00", bdat); end
`ifdef TIMEOUT_EN
    checks++; if (to_err !== 1'b0) begin failures++; $display("FAIL reset_to_err: got %b want 0", to_err); end
`endif
    tick();
    rst = 1'b0;
    repeat (2 * LAT + 2) tick();
    checks++; if (bvalid !== 1'b0 || aack !== 1'b0) begin failures++; $display("FAIL reset_idle: got bvalid=%b aack=%b want 0 0", bvalid, aack); end
  endtask

  task automatic test_basic(input int n);
    logic [DW-1:0] d;
    for (int w = 0; w < n; w++) begin
      d = (w == 0) ? 8'hA5 : 8'($urandom);
      exp_q.push_back(d);
      bready = 1'b1; adat = d; areq = 1'b1;
      for (int e = 1; e <= LAT; e++) begin
        tick();
        checks++; if (bvalid !== (e == LAT)) begin failures++; $display("FAIL basic_bvalid_lat: edge %0d got %b want %b", e, bvalid, (e == LAT)); end
      end
      d = exp_q.pop_front();
      checks++; if (bdat !== d) begin failures++; $display("FAIL basic_bdat: got %h want %h", bdat, d); end
      tick();
      checks++; if (bvalid !== 1'b0 || aack !== 1'b1) begin failures++; $display("FAIL basic_handoff: got bvalid=%b aack=%b want 0 1", bvalid, aack); end
      areq = 1'b0;
      for (int e = 1; e <= LAT; e++) begin
        tick();
        checks++; if (aack !== (e < LAT)) begin failures++; $display("FAIL basic_aack_fall: edge %0d got %b want %b", e, aack, (e < LAT)); end
      end
    end
    bready = 1'b0;
  endtask

  task automatic test_backpressure(input int n);
    logic [DW-1:0] d;
    int            hold;
    for (int w = 0; w < n; w++) begin
      d = (w == 0) ? 8'hA5 : 8'($urandom);
      hold = 10 + int'($urandom_range(0, 5));
      bready = 1'b0; adat = d; areq = 1'b1;
      repeat (LAT) tick();
      for (int i = 0; i < hold; i++) begin
        checks++; if (bvalid !== 1'b1 || bdat !== d || aack !== 1'b0) begin failures++; $display("FAIL bp_hold: cycle %0d got bvalid=%b bdat=%h aack=%b want 1 %h 0", i, bvalid, bdat, aack, d); end
        tick();
      end
      bready = 1'b1;
      tick();
      checks++; if (bvalid !== 1'b0 || aack !== 1'b1) begin failures++; $display("FAIL bp_release: got bvalid=%b aack=%b want 0 1", bvalid, aack); end
      bready = 1'b0; areq = 1'b0;
      repeat (LAT) tick();
      checks++; if (aack !== 1'b0) begin failures++; $display("FAIL bp_aack_fall: got %b want 0", aack); end
    end
  endtask

  task automatic test_reset_areq_high();
    int seen = 0;
    bready = 1'b1; adat = 8'($urandom); areq = 1'b1;
    repeat (LAT + 1) tick();
    checks++; if (aack !== 1'b1) begin failures++; $display("FAIL rah_in_ack: got aack=%b want 1", aack); end
    #4 rst = 1'b1;
    #1;
    checks++; if (aack !== 1'b0 || bvalid !== 1'b0) begin failures++; $display("FAIL rah_async: got aack=%b bvalid=%b want 0 0", aack, bvalid); end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bvalid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rah_no_accept: got %0d bvalid cycles want 0", seen); end
    areq = 1'b0;
    repeat (LAT + 2) tick();
    adat = 8'h3C; areq = 1'b1;
    repeat (LAT) tick();
    checks++; if (bvalid !== 1'b1 || bdat !== 8'h3C) begin failures++; $display("FAIL rah_new_word: got bvalid=%b bdat=%h want 1 3c", bvalid, bdat); end
    tick();
    areq = 1'b0; bready = 1'b0;
    repeat (LAT + 1) tick();
    checks++; if (aack !== 1'b0) begin failures++; $display("FAIL rah_done: got aack=%b want 0", aack); end
  endtask

  task automatic test_short_areq();
    logic [DW-1:0] d;
    int            wait_n;
    d = 8'($urandom);
    wait_n = int'($urandom_range(2, 8));
    bready = 1'b0; adat = d; areq = 1'b1;
    tick();
    areq = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (bvalid !== 1'b1 || bdat !== d) begin failures++; $display("FAIL short_capture: got bvalid=%b bdat=%h want 1 %h", bvalid, bdat, d); end
    repeat (wait_n) tick();
    checks++; if (bvalid !== 1'b1 || aack !== 1'b0) begin failures++; $display("FAIL short_wait: got bvalid=%b aack=%b want 1 0", bvalid, aack); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++; if (aack !== 1'b1 || bvalid !== 1'b0) begin failures++; $display("FAIL short_ack_rise: got aack=%b bvalid=%b want 1 0", aack, bvalid); end
    tick();
    checks++; if (aack !== 1'b0) begin failures++; $display("FAIL short_ack_pulse: got aack=%b want 0", aack); end
  endtask

  task automatic b2b_sender();
    int n;
    for (int i = 1; i <= 4; i++) begin
      @(posedge aclk);
      #2;
      adat = 8'(i);
      areq = 1'b1;
      exp_q.push_back(8'(i));
      n = 0;
      while (ack_s2 !== 1'b1 && n < 400) begin @(posedge aclk); n++; end
      checks++; if (n >= 400) begin failures++; $display("FAIL b2b_ack_rise_timeout: word %0d got no aack want aack=1", i); end
      #2 areq = 1'b0;
      n = 0;
      while (ack_s2 !== 1'b0 && n < 400) begin @(posedge aclk); n++; end
      checks++; if (n >= 400) begin failures++; $display("FAIL b2b_ack_fall_timeout: word %0d got aack stuck want 0", i); end
    end
    done = 1'b1;
  endtask

  task automatic b2b_ready();
    while (!done) begin
      @(posedge bclk);
      #1 bready = 1'($urandom_range(0, 1));
    end
    bready = 1'b0;
  endtask

  task automatic b2b_monitor();
    int            extra = 0;
    logic [DW-1:0] d;
    while (extra < 6) begin
      @(negedge bclk);
      if (done) extra++;
      if (bvalid === 1'b1 && bready === 1'b1) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_duplicate: got extra beat bdat=%h want none", bdat);
        end else begin
          d = exp_q.pop_front();
          if (bdat !== d) begin failures++; $display("FAIL b2b_order: got %h want %h", bdat, d); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    done  = 1'b0;
    beats = 0;
    fork
      b2b_sender();
      b2b_ready();
      b2b_monitor();
    join
    checks++; if (beats != 4) begin failures++; $display("FAIL b2b_beats: got %0d want 4", beats); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_pending: got %0d undelivered want 0", exp_q.size()); end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    bready = 1'b1; adat = 8'($urandom); areq = 1'b1;
    repeat (LAT + 1) tick();
    bready = 1'b0;
    checks++; if (aack !== 1'b1) begin failures++; $display("FAIL to_enter_ack: got aack=%b want 1", aack); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (to_err !== (k >= 16)) begin failures++; $display("FAIL to_err_cycle: cycle %0d got %b want %b", k, to_err, (k >= 16)); end
    end
    areq = 1'b0;
    repeat (LAT) tick();
    checks++; if (aack !== 1'b0 || to_err !== 1'b1) begin failures++; $display("FAIL to_complete: got aack=%b to_err=%b want 0 1", aack, to_err); end
    apply_reset();
    checks++; if (to_err !== 1'b0) begin failures++; $display("FAIL to_clear: got %b want 0", to_err); end
  endtask
`endif

  initial begin
    done = 1'b0;
    beats = 0;
    test_reset();
    test_basic(4);
    test_backpressure(3);
    test_reset_areq_high();
    test_short_areq();
    repeat (4) tick();
    test_back_to_back();
    repeat (4) tick();
    test_basic(2);
`ifdef TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion want finish");
    $fatal(1, "global timeout");
  end
endmodule
